// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern register.
// Bits are accepted only when valid_in is high. The newest bit enters at
// hist[0], so PATTERN[PAT_W-1] is matched against the oldest bit in the window.
// The detect pulse and the saturating match counter are both registered.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             seq_in,
  input  logic             valid_in,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             count_clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] active_pattern
);

  localparam int            FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] nxt_hist;
  logic [FW-1:0]    nxt_fill;
  logic             accept;
  logic             match;

  // Compute the post-shift window and post-increment fill for this edge.
  // A pattern load discards the coincident bit, so that edge never matches.
  always_comb begin
    accept   = valid_in && !cfg_we;
    nxt_hist = {hist[PAT_W-2:0], seq_in};
    nxt_fill = (fill == FULL) ? fill : fill + 1'b1;
    match    = accept && (nxt_hist == active_pattern) && (nxt_fill == FULL);
  end

  // State update. Reset has the highest priority, then a pattern load, then
  // an accepted bit. The counter clear overrides a coincident increment.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist           <= '0;
      fill           <= '0;
      detect         <= 1'b0;
      match_count    <= '0;
      active_pattern <= PATTERN;
    end else begin
      detect <= match;
      if (cfg_we) begin
        active_pattern <= pattern_i;
        hist           <= '0;
        fill           <= '0;
      end else if (valid_in) begin
        hist <= nxt_hist;
        if (match && (OVERLAP == 0))
          fill <= '0;
        else
          fill <= nxt_fill;
      end
      if (count_clr)
        match_count <= '0;
      else if (match && (match_count != {CNT_W{1'b1}}))
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Three instances share one stimulus stream:
// an overlapping instance, a non-overlapping instance, and an overlapping
// instance with a 2-bit counter. A queue-based model of the received stream
// predicts every output, and the outputs are compared on each falling edge.
module tb_seq_detector_param;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       seq_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] pattern_i = 4'd0;
  logic       count_clr = 1'b0;

  logic       det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [3:0] pat0, pat1, pat2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u_ovl (
    .clk_i(clk_i), .reset_i(reset_i), .seq_in(seq_in), .valid_in(valid_in),
    .cfg_we(cfg_we), .pattern_i(pattern_i), .count_clr(count_clr),
    .detect(det0), .match_count(cnt0), .active_pattern(pat0));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) u_novl (
    .clk_i(clk_i), .reset_i(reset_i), .seq_in(seq_in), .valid_in(valid_in),
    .cfg_we(cfg_we), .pattern_i(pattern_i), .count_clr(count_clr),
    .detect(det1), .match_count(cnt1), .active_pattern(pat1));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2)) u_sat (
    .clk_i(clk_i), .reset_i(reset_i), .seq_in(seq_in), .valid_in(valid_in),
    .cfg_we(cfg_we), .pattern_i(pattern_i), .count_clr(count_clr),
    .detect(det2), .match_count(cnt2), .active_pattern(pat2));

  // Model: the bits received since the last clear, and for each instance the
  // number of bits that count toward its next match.
  bit       hq[$];
  logic [3:0] epat;
  int       run[3];
  int       ecnt[3];
  int       edet[3];
  int       ovl[3]  = '{1, 0, 1};
  int       cmax[3] = '{255, 255, 3};

  always @(posedge clk_i) begin
    logic [3:0] win;
    bit hit;
    if (reset_i) begin
      hq.delete();
      epat = 4'b1101;
      for (int k = 0; k < 3; k++) begin
        run[k] = 0; ecnt[k] = 0; edet[k] = 0;
      end
    end else begin
      if (cfg_we) begin
        epat = pattern_i;
        hq.delete();
      end else if (valid_in) begin
        hq.push_back(seq_in);
        if (hq.size() > 4) void'(hq.pop_front());
      end
      win = 4'd0;
      for (int i = 0; i < hq.size(); i++) win = {win[2:0], hq[i]};
      for (int k = 0; k < 3; k++) begin
        hit = 1'b0;
        if (cfg_we) run[k] = 0;
        else if (valid_in) begin
          run[k]++;
          if (run[k] >= 4 && win == epat) begin
            hit = 1'b1;
            if (ovl[k] == 0) run[k] = 0;
          end
        end
        edet[k] = int'(hit);
        if (count_clr) ecnt[k] = 0;
        else if (hit && ecnt[k] < cmax[k]) ecnt[k]++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("det_ovl",  int'(det0), edet[0]);
      chk("det_novl", int'(det1), edet[1]);
      chk("det_sat",  int'(det2), edet[2]);
      chk("cnt_ovl",  int'(cnt0), ecnt[0]);
      chk("cnt_novl", int'(cnt1), ecnt[1]);
      chk("cnt_sat",  int'(cnt2), ecnt[2]);
      chk("pat_ovl",  int'(pat0), int'(epat));
      chk("pat_novl", int'(pat1), int'(epat));
      chk("pat_sat",  int'(pat2), int'(epat));
    end
  end

  task automatic step(input logic r, input logic v, input logic b,
                      input logic we, input logic [3:0] p, input logic clr);
    reset_i = r; valid_in = v; seq_in = b; cfg_we = we; pattern_i = p; count_clr = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic bitin(input logic b);
    step(1'b0, 1'b1, b, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bitin(bits[i]);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk_en = 1'b1;
    chk("rst_det", int'(det0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_pat", int'(pat0), 4'b1101);

    // Stream 1,1,0,1,1,0,1: overlapping vs non-overlapping
    feed(32'b1101, 4);
    chk("s1_det4_ovl",  int'(det0), 1);
    chk("s1_det4_novl", int'(det1), 1);
    bitin(1'b1);
    chk("s1_det5_ovl",  int'(det0), 0);
    feed(32'b01, 2);
    chk("s1_det7_ovl",  int'(det0), 1);
    chk("s1_det7_novl", int'(det1), 0);
    chk("s1_cnt_ovl",   int'(cnt0), 2);
    chk("s1_cnt_novl",  int'(cnt1), 1);

    // Bubbles with seq_in toggling while invalid
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    feed(32'b11, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("s2_bubble_det", int'(det0), 0);
    feed(32'b01, 2);
    chk("s2_det", int'(det0), 1);
    chk("s2_cnt", int'(cnt0), 1);

    // Pattern load discards prior bits and the coincident bit
    feed(32'b11, 2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    chk("s3_cfg_det", int'(det0), 0);
    chk("s3_pat", int'(pat0), 4'b0110);
    feed(32'b0110, 4);
    chk("s3_det", int'(det0), 1);
    chk("s3_cnt", int'(cnt0), 2);

    // Counter clear coincident with an overlapping match
    feed(32'b11, 2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("s4_det", int'(det0), 1);
    chk("s4_cnt", int'(cnt0), 0);
    chk("s4_det_novl", int'(det1), 0);

    // Five overlapping matches saturate the 2-bit counter
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    feed(32'hDB6D, 16);
    chk("s5_det", int'(det0), 1);
    chk("s5_cnt_ovl", int'(cnt0), 5);
    chk("s5_cnt_sat", int'(cnt2), 3);

    // All-ones pattern
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    feed(32'b111111, 6);
    chk("s6_det_ovl",  int'(det0), 1);
    chk("s6_det_novl", int'(det1), 0);
    chk("s6_cnt_ovl",  int'(cnt0), 8);

    // Reset priority over cfg_we, and mid-pattern reset
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
    chk("s7_pat_prio", int'(pat0), 4'b1101);
    feed(32'b110, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    bitin(1'b1);
    chk("s7_no_det", int'(det0), 0);
    feed(32'b1101, 4);
    chk("s7_det", int'(det0), 1);
    chk("s7_cnt", int'(cnt0), 1);

    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk_i and reset_i.
REQ-002 Parameter PAT_W, default 4, SHALL set the pattern length in bits (legal 2..16).
REQ-003 Parameter PATTERN, default 4'b1101, SHALL set the reset-time pattern; PATTERN[PAT_W-1] is the first bit received.
REQ-004 Parameter OVERLAP, default 1, SHALL select the matching mode: 1 = overlapping, 0 = non-overlapping.
REQ-005 Parameter CNT_W, default 8, SHALL set the width of the match counter.
REQ-006 Ports (name, direction, width, meaning):
- clk_i  in  1  rising-edge clock.
- reset_i  in  1  synchronous active-high reset.
- seq_in  in  1  serial data bit.
- valid_in  in  1  seq_in is sampled only on edges where this is 1.
- cfg_we  in  1  load pattern_i into the active pattern register.
- pattern_i  in  PAT_W  runtime pattern value.
- count_clr  in  1  clear the match counter.
- detect  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- active_pattern  out  PAT_W  current pattern register.

Function
REQ-007 History register hist[PAT_W-1:0] SHALL update on each edge with valid_in=1: hist <= {hist[PAT_W-2:0], seq_in}.
REQ-008 Fill counter fill (0..PAT_W) SHALL increment on each accepted bit and saturate at PAT_W.
REQ-009 A match SHALL be declared on an edge that accepts a bit when the post-shift window equals active_pattern and the post-increment fill equals PAT_W.
REQ-010 detect SHALL be 1 for exactly the one cycle following a match edge and 0 otherwise; it is a Moore-style registered output with no combinational path from seq_in.
REQ-011 With OVERLAP=1, hist and fill SHALL be retained after a match, so overlapping occurrences are each detected.
REQ-012 With OVERLAP=0, fill SHALL be forced to 0 on the match edge, so the next match requires PAT_W fresh accepted bits.
REQ-013 Edges with valid_in=0 SHALL leave hist, fill and match_count unchanged and SHALL drive detect to 0.
REQ-014 match_count SHALL increment by 1 on each match edge and saturate at 2^CNT_W-1 without wrapping.
REQ-015 count_clr=1 SHALL set match_count to 0; clear wins over a coincident match (count=0), while detect still pulses.
REQ-016 cfg_we=1 SHALL load pattern_i into active_pattern and clear hist and fill on that edge.
REQ-017 On a cfg_we edge, any coincident valid_in bit SHALL be discarded, detect SHALL be 0 the following cycle, and match_count SHALL be unaffected.
REQ-018 A pattern of all zeros or all ones SHALL be legal and behave per REQ-009..REQ-012 with no special casing.

Reset
REQ-019 Reset SHALL drive the following on the first reset edge: detect=0, match_count=0, hist=0, fill=0, active_pattern=PATTERN.
REQ-020 Reset SHALL take priority over cfg_we, count_clr and valid_in.
REQ-021 Reset asserted mid-pattern SHALL discard all partial history.

Verification
REQ-022 Defaults, OVERLAP=1, valid_in=1, stream 1,1,0,1,1,0,1 SHALL give detect pulses after bits 4 and 7, and match_count=2.
REQ-023 Same stream with OVERLAP=0 SHALL give a detect pulse after bit 4 only, and match_count=1.
REQ-024 Stream 1,1,0,1 with valid_in=0 inserted between bits 2 and 3 (seq_in toggling while invalid) SHALL give a single detect after bit 4.
REQ-025 cfg_we with pattern_i=4'b0110, then stream 0,1,1,0 SHALL give active_pattern=0110 and detect after bit 4; bits received before cfg_we SHALL not contribute.
REQ-026 CNT_W=2 with 5 matches SHALL hold match_count at 3; count_clr coincident with a match SHALL give match_count=0 and detect=1.
REQ-027 reset_i asserted after bits 1,1,0, then bit 1 SHALL give no detect, and a fresh 1,1,0,1 SHALL give detect.
